uart_receive: RTL and testbench
===============================

// Module: uart_receive
// PURPOSE
//  UART receiver: 8N1 frames (start 0, 8 data bits LSB first, stop 1) on serial
//  input uart_rx, recovered into a parallel byte.
//  Counterpart of the UART transmit path, at the same bit rate: 9600 baud at 100 MHz.
//  Delivers each byte with a one-cycle data_valid strobe to downstream logic.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk cycles per bit period (100 MHz / 9600)
//  TMR_WIDTH     14     bit-timer width; must hold CLKS_PER_BIT-1
//  DATA_BITS     8      data bits per frame
// PORTS
//  clk         in   1          clock; all logic on posedge clk
//  rst         in   1          reset, synchronous, active-high
//  uart_rx     in   1          async serial line, idles high
//  data        out  DATA_BITS  last good byte; held until next good frame
//  data_valid  out  1          1-cycle strobe: data updated this cycle
//  frame_err   out  1          1-cycle strobe: stop bit sampled 0
//  busy        out  1          high while state != IDLE
//  parity_err  out  1          only with UART_RX_PARITY_EN; 1-cycle strobe
// BEHAVIOUR
//  Reset: state IDLE; data=0; data_valid=frame_err=busy=parity_err=0;
//   sync flops=1; bit timer and bit index=0. rst mid-frame aborts; no strobe.
//  Sync: uart_rx through 2 flops (rx_s) before any use; adds 2 clk latency.
//  Timer: counts 0..CLKS_PER_BIT-1, then wraps to 0; cleared on every state entry.
//  States:
//   IDLE  : rx_s==0 -> START
//   START : at timer==CLKS_PER_BIT/2-1 (mid start bit) sample rx_s:
//           0 -> DATA, index=0; 1 -> IDLE (glitch rejected, no strobe)
//   DATA  : every CLKS_PER_BIT clks (mid-bit) shift rx_s into MSB of shift reg
//           (LSB first on line); after DATA_BITS samples -> STOP
//           (-> PARITY when the macro is defined)
//   STOP  : mid stop bit sample rx_s:
//           1 -> data<=shift reg, data_valid=1, -> IDLE
//           0 -> frame_err=1, data unchanged, -> BREAK
//   BREAK : wait for rx_s==1, then -> IDLE (no new start during a break)
//  Latency: data_valid asserts the cycle after the mid-stop-bit sample.
//  IDLE is entered mid-stop-bit, so a start edge half a bit later is caught:
//   back-to-back frames with zero idle gap are received.
//  Strobes never assert together; data_valid never coincides with an error.
//  No downstream backpressure: a byte not consumed at data_valid is overwritten
//   by the next good frame. No overrun flag.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - frame gains an even-parity bit after the data bits (8E1).
//   - PARITY state samples it mid-bit, then -> STOP.
//   - Good stop bit + parity mismatch: parity_err=1, data_valid=0, data unchanged.
//   - parity_err port exists.
//  UART_RX_PARITY_EN undefined:
//   - 8N1 only; no PARITY state; no parity_err port.
// TESTING (bench uses CLKS_PER_BIT=16)
//  1 Frame 0x55 with 1-bit idle before -> data=0x55, one data_valid pulse,
//    frame_err=0, busy low after.
//  2 Frames 0xA3 then 0x0F back-to-back, zero gap -> two data_valid pulses,
//    data=0xA3 then 0x0F.
//  3 uart_rx low for 4 clks, then high -> START then IDLE, no strobes,
//    data unchanged.
//  4 Frame 0x7E with stop=0, line held low 40 clks, then frame 0x81 ->
//    frame_err pulse, no data_valid; then data=0x81 with data_valid.
//  5 rst asserted mid-DATA of 0xC6 -> all outputs 0 the next cycle;
//    following frame 0x3C -> data=0x3C.
//  6 (PARITY_EN) 0x01 with parity=1 -> data_valid;
//    0x01 with parity=0 -> parity_err pulse, data keeps 0x01 from first frame.

Source files
------------

// File: rtl/uart_receive.sv
// uart_receive: 8N1 UART receiver, 2-flop input sync, mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err strobe.
module uart_receive #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int TMR_WIDTH    = 14,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam logic [TMR_WIDTH-1:0] T_LAST =
        TMR_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [TMR_WIDTH-1:0] T_MID =
        TMR_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic [TMR_WIDTH-1:0] tmr;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    assign bit_end = (tmr == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            idx        <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            tmr <= bit_end ? '0 : tmr + 1'b1;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        tmr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    // Realign the timer to mid-bit for all later samples
                    if (tmr == T_MID) begin
                        tmr <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == I_LAST) begin
                            tmr <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        par_bad <= ^{shreg, rx_s};
                        state   <= STOP;
                        tmr     <= '0;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        tmr <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                data       <= shreg;
                                data_valid <= 1'b1;
                            end
`else
                            data       <= shreg;
                            data_valid <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tmr   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tmr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed + random frames against a frame-level model.
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_receive;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] dv_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt   = 0;
    int         pe_cnt   = 0;
    int         both_cnt = 0;
    int         exp_fe   = 0;
    int         exp_pe   = 0;
    logic [7:0] exp_data = 8'h00;

    always #5 clk = ~clk;

    uart_receive #(
        .CLKS_PER_BIT(CPB),
        .TMR_WIDTH   (14),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) dv_q.push_back(data);
            if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
            if (data_valid && (frame_err || parity_err)) both_cnt++;
`else
            if (data_valid && frame_err) both_cnt++;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Frame-level model: a good frame yields its byte, a 0 stop bit a
    // frame error, a good stop with bad parity a parity error.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic par_good);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_good ? ^b : ~^b);
`endif
        send_bit(stop);
        if (!stop) begin
            exp_fe++;
        end else if (!par_good) begin
            exp_pe++;
        end else begin
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    task automatic check_model(input string tag);
        #1;
        check({tag, "_nvalid"}, 32'(dv_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_byte"},
                  (i < dv_q.size()) ? 32'(dv_q[i]) : 32'hx,
                  32'(exp_q[i]));
        end
        check({tag, "_ferr"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_perr"}, 32'(pe_cnt), 32'(exp_pe));
        check({tag, "_overlap"}, 32'(both_cnt), 32'd0);
        check({tag, "_data"}, 32'(data), 32'(exp_data));
        dv_q.delete();
        exp_q.delete();
        fe_cnt = 0;
        pe_cnt = 0;
        exp_fe = 0;
        exp_pe = 0;
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        logic       pg;

        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        idle_bits(1);
        send_frame(8'h55, 1'b1, 1'b1);
        idle_bits(1);
        check_model("t1");
        check("t1_busy", 32'(busy), 32'h0);

        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1);
        idle_bits(1);
        check_model("t2");

        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("t3_busy_glitch", 32'(busy), 32'h1);
        uart_rx = 1'b1;
        idle_bits(2);
        check_model("t3");
        check("t3_busy_after", 32'(busy), 32'h0);

        send_frame(8'h7E, 1'b0, 1'b1);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("t4_busy_break", 32'(busy), 32'h1);
        check_model("t4a");
        idle_bits(1);
        send_frame(8'h81, 1'b1, 1'b1);
        idle_bits(1);
        check_model("t4b");

        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst     = 1'b1;
        uart_rx = 1'b1;
        @(negedge clk);
        #1;
        check("t5_data", 32'(data), 32'h0);
        check("t5_valid", 32'(data_valid), 32'h0);
        check("t5_ferr", 32'(frame_err), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        rst      = 1'b0;
        exp_data = 8'h00;
        idle_bits(2);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(1);
        check_model("t5");

        for (int k = 0; k < 12; k++) begin
            idle_bits(int'($urandom_range(0, 2)));
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            pg   = ($urandom_range(0, 2) != 0);
`else
            pg   = 1'b1;
`endif
            send_frame(b, stop, pg);
            if (!stop) begin
                uart_rx = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
                idle_bits(1);
            end
        end
        idle_bits(1);
        check_model("rand");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1);
        idle_bits(1);
        check_model("t6a");
        send_frame(8'h01, 1'b1, 1'b0);
        idle_bits(1);
        check_model("t6b");
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
